// File: rtl/sort3_share_scheduler.sv
// sort3_share_scheduler
// Time-shares one registered 3-input sorter among NUM_REQ requesters.
// A round-robin arbiter registers the winning triple into the sorter.
// A tag pipe carries the requester ID alongside the sorter latency.
// A credit-protected result FIFO absorbs downstream backpressure.
// Optional feature macro: SORT_SCHED_PRIO0_EN gives requester 0 strict priority.
module sort3_share_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int SORT_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               i_clk,
    input  logic                               i_areset,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]    i_req_data,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    output logic [DATA_WIDTH-1:0]              o_sort_in_1,
    output logic [DATA_WIDTH-1:0]              o_sort_in_2,
    output logic [DATA_WIDTH-1:0]              o_sort_in_3,
    input  logic [DATA_WIDTH-1:0]              i_sort_high,
    input  logic [DATA_WIDTH-1:0]              i_sort_med,
    input  logic [DATA_WIDTH-1:0]              i_sort_low,
    output logic                               o_rsp_valid,
    input  logic                               i_rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]         o_rsp_id,
    output logic [DATA_WIDTH-1:0]              o_rsp_high,
    output logic [DATA_WIDTH-1:0]              o_rsp_med,
    output logic [DATA_WIDTH-1:0]              o_rsp_low
);

    localparam int ID_W     = $clog2(NUM_REQ);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int TRIPLE_W = 3 * DATA_WIDTH;
    localparam int PIPE_N   = SORT_LATENCY + 1;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] high;
        logic [DATA_WIDTH-1:0] med;
        logic [DATA_WIDTH-1:0] low;
    } rsp_t;

    // Arbiter state and decisions
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic                can_issue;
    logic                accept;
    logic [TRIPLE_W-1:0] req_triple [NUM_REQ];
    logic [TRIPLE_W-1:0] granted_triple;
    int                  inflight;

    // Sorter operand registers and tag pipe
    logic [DATA_WIDTH-1:0] sort_in_1_q, sort_in_2_q, sort_in_3_q;
    logic [PIPE_N-1:0]     tag_valid_q;
    logic [ID_W-1:0]       tag_id_q [PIPE_N];

    // Result FIFO
    rsp_t             fifo_mem_q [FIFO_DEPTH];
    rsp_t             fifo_head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic             push, do_push, pop, full;
    logic             overflow;

    // Unpack the flat request bus into one triple per requester.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_triple[k] = i_req_data[k*TRIPLE_W +: TRIPLE_W];
        end
    end

    // Credit: FIFO occupancy plus tags still travelling through the sorter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        inflight = 0;
        for (int k = 0; k < PIPE_N; k++) begin
            if (tag_valid_q[k]) inflight = inflight + 1;
        end
        can_issue = !i_areset && ((int'(fifo_count_q) + inflight) < FIFO_DEPTH);
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin : arb_comb
        int              idx;
        logic [ID_W-1:0] idx_sel;
        idx         = 0;
        idx_sel     = '0;
        grant_found = 1'b0;
        grant_id    = '0;
`ifdef SORT_SCHED_PRIO0_EN
        if (i_req_valid[0]) begin
            grant_found = 1'b1;
            grant_id    = '0;
        end
`endif
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_sel = idx[ID_W-1:0];
            if (!grant_found && i_req_valid[idx_sel]) begin
                grant_found = 1'b1;
                grant_id    = idx_sel;
            end
        end
    end

    // Accept, one-hot ready and pointer update derived from the arbiter result.
    always_comb begin
        accept         = grant_found && can_issue;
        granted_triple = req_triple[grant_id];
        o_req_ready    = '0;
        if (accept) o_req_ready[grant_id] = 1'b1;
        last_grant_d = last_grant_q;
`ifdef SORT_SCHED_PRIO0_EN
        if (accept && (grant_id != '0)) last_grant_d = grant_id;
`else
        if (accept) last_grant_d = grant_id;
`endif
    end

    // Register the granted operands and advance the tag pipe every cycle.
    always_ff @(posedge i_clk or posedge i_areset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_areset) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            sort_in_1_q  <= '0;
            sort_in_2_q  <= '0;
            sort_in_3_q  <= '0;
            tag_valid_q  <= '0;
            for (int k = 0; k < PIPE_N; k++) tag_id_q[k] <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            if (accept) begin
                sort_in_1_q <= granted_triple[DATA_WIDTH-1:0];
                sort_in_2_q <= granted_triple[2*DATA_WIDTH-1:DATA_WIDTH];
                sort_in_3_q <= granted_triple[3*DATA_WIDTH-1:2*DATA_WIDTH];
            end
            tag_valid_q <= {tag_valid_q[PIPE_N-2:0], accept};
            tag_id_q[0] <= grant_id;
            for (int k = 1; k < PIPE_N; k++) tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    assign o_sort_in_1 = sort_in_1_q;
    assign o_sort_in_2 = sort_in_2_q;
    assign o_sort_in_3 = sort_in_3_q;

    // FIFO push/pop decisions and next pointer/count values.
    always_comb begin
        push         = tag_valid_q[PIPE_N-1];
        full         = (fifo_count_q == CNT_W'(FIFO_DEPTH));
        overflow     = push && full;
        do_push      = push && !full;
        pop          = o_rsp_valid && i_rsp_ready;
        wr_ptr_d     = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (do_push && !pop)      fifo_count_d = fifo_count_q + 1'b1;
        else if (!do_push && pop) fifo_count_d = fifo_count_q - 1'b1;
    end

    // Capture sorter results into the FIFO and track its pointers.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            // NOTE: the storage is tiny and drives o_rsp_* directly, so it is reset to give defined outputs.
            for (int k = 0; k < FIFO_DEPTH; k++) fifo_mem_q[k] <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            if (do_push) begin
                fifo_mem_q[wr_ptr_q] <= '{id:   tag_id_q[PIPE_N-1],
                                          high: i_sort_high,
                                          med:  i_sort_med,
                                          low:  i_sort_low};
            end
        end
    end

    assign fifo_head   = fifo_mem_q[rd_ptr_q];
    assign o_rsp_valid = (fifo_count_q != '0);
    assign o_rsp_id    = fifo_head.id;
    assign o_rsp_high  = fifo_head.high;
    assign o_rsp_med   = fifo_head.med;
    assign o_rsp_low   = fifo_head.low;

    // Credit accounting must make a capture into a full FIFO impossible.
    overflow_never : assert property (@(posedge i_clk) disable iff (i_areset) !overflow);

endmodule

// File: tb/tb_sort3_share_scheduler.sv
// Directed bench for sort3_share_scheduler with a behavioural registered sorter.
module tb_sort3_share_scheduler;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int RW = NR * 3 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [RW-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic [DW-1:0] sort_in_1, sort_in_2, sort_in_3;
    logic [DW-1:0] sort_high, sort_med, sort_low;
    logic          rsp_valid, rsp_ready;
    logic [1:0]    rsp_id;
    logic [DW-1:0] rsp_high, rsp_med, rsp_low;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sort3_share_scheduler #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .SORT_LATENCY(1), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk), .i_areset(rst),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .o_sort_in_1(sort_in_1), .o_sort_in_2(sort_in_2), .o_sort_in_3(sort_in_3),
        .i_sort_high(sort_high), .i_sort_med(sort_med), .i_sort_low(sort_low),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_high(rsp_high), .o_rsp_med(rsp_med), .o_rsp_low(rsp_low)
    );

    function automatic logic [3*DW-1:0] sort3(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] hi, lo, md;
        hi = (a >= b) ? ((a >= c) ? a : c) : ((b >= c) ? b : c);
        lo = (a <= b) ? ((a <= c) ? a : c) : ((b <= c) ? b : c);
        md = DW'(({2'b0, a} + {2'b0, b} + {2'b0, c}) - {2'b0, hi} - {2'b0, lo});
        return {hi, md, lo};
    endfunction

    // Behavioural sorter with one register stage.
    always_ff @(posedge clk) begin
        {sort_high, sort_med, sort_low} <= sort3(sort_in_1, sort_in_2, sort_in_3);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] a, b, c);
        logic [RW-1:0] mask, val;
        mask     = RW'(24'hFFFFFF) << (k * 3 * DW);
        val      = RW'({c, b, a}) << (k * 3 * DW);
        req_data = (req_data & ~mask) | val;
    endtask

    // Leaves the bench at a falling edge with reset released: the next cycle is cycle 0.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int rr_id(input int c);
`ifdef SORT_SCHED_PRIO0_EN
        return 0;
`else
        return c % NR;
`endif
    endfunction

    function automatic int p0_grant(input int c);
`ifdef SORT_SCHED_PRIO0_EN
        return 1;
`else
        return (c % 2 == 1) ? 4 : 1;
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_sort_in_1", 32'(sort_in_1), 0);
        check("rst_rsp_high", 32'(rsp_high), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic latency: requester 1 presents (10,5,7).
        set_req(1, 8'd10, 8'd5, 8'd7);
        req_valid = 4'b0010;
        #1 check("lat_ready_c0", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("lat_sort_in_1", 32'(sort_in_1), 10);
        check("lat_sort_in_2", 32'(sort_in_2), 5);
        check("lat_sort_in_3", 32'(sort_in_3), 7);
        check("lat_valid_c1", 32'(rsp_valid), 0);
        @(negedge clk);
        #1 check("lat_valid_c2", 32'(rsp_valid), 0);
        @(negedge clk);
        #1;
        check("lat_valid_c3", 32'(rsp_valid), 1);
        check("lat_id", 32'(rsp_id), 1);
        check("lat_high", 32'(rsp_high), 10);
        check("lat_med", 32'(rsp_med), 7);
        check("lat_low", 32'(rsp_low), 5);
        @(negedge clk);
        #1 check("lat_valid_c4", 32'(rsp_valid), 0);

        // Round-robin with all requesters valid.
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, DW'(k*16+3), DW'(k*16+9), DW'(k*16+1));
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            if (c < 8) check("rr_grant", 32'(req_ready), 32'(1 << rr_id(c)));
            if (c >= 3 && c < 11) begin
                check("rr_rsp_valid", 32'(rsp_valid), 1);
                check("rr_rsp_id", 32'(rsp_id), 32'(rr_id(c-3)));
                check("rr_rsp_high", 32'(rsp_high), 32'(rr_id(c-3)*16+9));
                check("rr_rsp_med", 32'(rsp_med), 32'(rr_id(c-3)*16+3));
                check("rr_rsp_low", 32'(rsp_low), 32'(rr_id(c-3)*16+1));
            end
            if (c == 11) check("rr_drained", 32'(rsp_valid), 0);
            @(negedge clk);
        end

        // Backpressure: four accepts fill the credit, ready=1 drains.
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 8'd180, 8'd180, 8'd180);
        req_valid = 4'b0001;
        for (int c = 0; c < 11; c++) begin
            if (c == 7) rsp_ready = 1'b1;
            if (c == 9) req_valid = '0;
            #1;
            if (c < 4)       check("bp_grant", 32'(req_ready), 1);
            else if (c < 8) check("bp_stall", 32'(req_ready), 0);
            else if (c == 8) check("bp_resume", 32'(req_ready), 1);
            if (c >= 6) begin
                check("bp_rsp_valid", 32'(rsp_valid), 1);
                check("bp_high", 32'(rsp_high), 180);
                check("bp_med", 32'(rsp_med), 180);
                check("bp_low", 32'(rsp_low), 180);
            end
            @(negedge clk);
        end

        // Reset mid-flight after accepting (100,255,150) from requester 2.
        do_reset();
        set_req(2, 8'd100, 8'd255, 8'd150);
        req_valid = 4'b0100;
        #1 check("mid_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        #1 check("mid_sort_in_2", 32'(sort_in_2), 255);
        @(negedge clk);
        req_valid = '1;
        rst       = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_sort_in_1", 32'(sort_in_1), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 check("mid_no_stale", 32'(rsp_valid), 0);
            @(negedge clk);
        end
        req_valid = '1;
        #1 check("mid_first_grant", 32'(req_ready), 1);

        // Requesters 0 and 2 always valid.
        do_reset();
        set_req(0, 8'd1, 8'd2, 8'd3);
        set_req(2, 8'd6, 8'd4, 8'd5);
        req_valid = 4'b0101;
        for (int c = 0; c < 7; c++) begin
            #1;
            check("p0_grant", 32'(req_ready), 32'(p0_grant(c)));
            if (c >= 3) begin
                check("p0_rsp_id", 32'(rsp_id), (p0_grant(c-3) == 1) ? 0 : 2);
                check("p0_rsp_med", 32'(rsp_med), (p0_grant(c-3) == 1) ? 2 : 5);
            end
            @(negedge clk);
        end
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
